// File: rtl/jtdd_snd_mix_if.sv
// Sound-CPU configuration port of the JTDD sound mixer.
// Carries the gain/control register write strobe, address, write data and read data.
`timescale 1ns/1ps

interface jtdd_snd_mix_if;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_din;
  logic [7:0] cfg_dout;

  modport master (output cfg_we, cfg_addr, cfg_din, input  cfg_dout);
  modport slave  (input  cfg_we, cfg_addr, cfg_din, output cfg_dout);
endinterface

// File: rtl/jtdd_snd_mix.sv
// Time-multiplexed JTDD sound mixer: one multiply-accumulate per clk across CH channels,
// 4.4 unsigned gains, per-channel mute, saturated output and sticky clip/overrun flags.
`timescale 1ns/1ps

module jtdd_snd_mix #(
  parameter int         CH       = 4,
  parameter int         W        = 16,
  parameter int         OW       = 16,
  parameter logic [7:0] GAIN_RST = 8'h10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cen,
  input  logic [CH*W-1:0]      ch_data,
  jtdd_snd_mix_if.slave        cfg,
  output logic signed [OW-1:0] sound,
  output logic                 sample,
  output logic                 clip,
  output logic                 overrun
);
  localparam int PW = W + 9;
  localparam int IW = $clog2(CH);
  localparam int AW = PW + IW;

  localparam logic signed [AW-1:0] RES_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] RES_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  state_t state_q, state_d;

  logic [7:0]          gain_q  [CH];
  logic [7:0]          gain_d  [CH];
  logic [CH-1:0]       mute_q, mute_d;
  logic signed [W-1:0] sdata_q [CH];
  logic signed [W-1:0] sdata_d [CH];
  logic [7:0]          sgain_q [CH];
  logic [7:0]          sgain_d [CH];
  logic [CH-1:0]       smute_q, smute_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [OW-1:0] sound_q, sound_d;
  logic                sample_q, sample_d;
  logic                clip_q, clip_d;
  logic                overrun_q, overrun_d;

  logic signed [W-1:0] ch_slice [CH];
  logic start, mac_en, out_en, busy_cen;

  for (genvar gi = 0; gi < CH; gi++) begin : g_slice
    assign ch_slice[gi] = ch_data[gi*W +: W];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cen) state_d = ST_MAC;
      ST_MAC:  if (idx_q == IW'(CH-1)) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    start    = 1'b0;
    mac_en   = 1'b0;
    out_en   = 1'b0;
    busy_cen = 1'b0;
    case (state_q)
      ST_IDLE: start = cen;
      ST_MAC:  begin mac_en = 1'b1; busy_cen = cen; end
      ST_OUT:  begin out_en = 1'b1; busy_cen = cen; end
      default: ;
    endcase
  end

  logic signed [PW-1:0] prod_data, prod_gain, prod;
  logic signed [AW-1:0] res;
  logic signed [OW-1:0] res_sat;
  logic                 res_clip;
  logic                 ctrl_wr;

  always_comb begin
    // Gain is unsigned: zero-extend before the signed multiply.
    prod_data = {{9{sdata_q[idx_q][W-1]}}, sdata_q[idx_q]};
    prod_gain = {{(PW-8){1'b0}}, sgain_q[idx_q]};
    prod      = smute_q[idx_q] ? '0 : prod_data * prod_gain;

    res = acc_q >>> 4;
    if (res > RES_MAX) begin
      res_sat  = {1'b0, {(OW-1){1'b1}}};
      res_clip = 1'b1;
    end else if (res < RES_MIN) begin
      res_sat  = {1'b1, {(OW-1){1'b0}}};
      res_clip = 1'b1;
    end else begin
      res_sat  = res[OW-1:0];
      res_clip = 1'b0;
    end
  end

  always_comb begin
    ctrl_wr   = cfg.cfg_we && (cfg.cfg_addr == 4'hF);
    gain_d    = gain_q;
    mute_d    = mute_q;
    sdata_d   = sdata_q;
    sgain_d   = sgain_q;
    smute_d   = smute_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sound_d   = sound_q;
    sample_d  = out_en;
    clip_d    = clip_q | (out_en & res_clip);
    overrun_d = overrun_q | busy_cen;

    for (int i = 0; i < CH; i++) begin
      if (cfg.cfg_we && (cfg.cfg_addr == 4'(i))) gain_d[i] = cfg.cfg_din;
    end
    if (ctrl_wr) begin
      for (int i = 0; i < CH; i++) mute_d[i] = (i == 7) ? 1'b0 : cfg.cfg_din[i];
      // Clear beats a set landing in the same clk.
      if (cfg.cfg_din[7]) begin
        clip_d    = 1'b0;
        overrun_d = 1'b0;
      end
    end

    if (start) begin
      sdata_d = ch_slice;
      sgain_d = gain_q;
      smute_d = mute_q;
      idx_d   = '0;
      acc_d   = '0;
    end
    if (mac_en) begin
      acc_d = acc_q + {{IW{prod[PW-1]}}, prod};
      idx_d = idx_q + IW'(1);
    end
    if (out_en) sound_d = res_sat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        gain_q[i]  <= GAIN_RST;
        sdata_q[i] <= '0;
        sgain_q[i] <= '0;
      end
      mute_q    <= '0;
      smute_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      sound_q   <= '0;
      sample_q  <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      gain_q    <= gain_d;
      sdata_q   <= sdata_d;
      sgain_q   <= sgain_d;
      mute_q    <= mute_d;
      smute_q   <= smute_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sound_q   <= sound_d;
      sample_q  <= sample_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  logic [7:0] mute_ext;

  always_comb begin
    mute_ext = 8'(mute_q);
    cfg.cfg_dout = 8'hFF;
    if (cfg.cfg_addr == 4'hF) cfg.cfg_dout = {clip_q, overrun_q, mute_ext[5:0]};
    for (int i = 0; i < CH; i++) begin
      if (cfg.cfg_addr == 4'(i)) cfg.cfg_dout = gain_q[i];
    end
  end

  assign sound   = sound_q;
  assign sample  = sample_q;
  assign clip    = clip_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_jtdd_snd_mix.sv
// Directed bench for jtdd_snd_mix (CH=4, W=16, OW=16): vector table plus
// hand-written overrun, flag-clear, address-decode and mid-frame reset sequences.
`timescale 1ns/1ps

module tb_jtdd_snd_mix;
  logic               clk = 1'b0;
  logic               rstn;
  logic               cen;
  logic [63:0]        ch_data;
  logic signed [15:0] sound;
  logic               sample, clip, overrun;
  int                 n_checks = 0;
  int                 n_errors = 0;

  jtdd_snd_mix_if cfg_if ();

  jtdd_snd_mix #(.CH(4), .W(16), .OW(16), .GAIN_RST(8'h10)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cen     (cen),
    .ch_data (ch_data),
    .cfg     (cfg_if.slave),
    .sound   (sound),
    .sample  (sample),
    .clip    (clip),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [31:0] gains;
    logic [3:0]  mute;
    int          exp_sound;
    logic        exp_clip;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] pack(input int a0, a1, a2, a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic vec_t mk(input string n, input logic [63:0] d, input logic [31:0] g,
                              input logic [3:0] m, input int s, input logic c);
    vec_t v;
    v.name = n; v.data = d; v.gains = g; v.mute = m; v.exp_sound = s; v.exp_clip = c;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_din = d;
    tick();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic cfg_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    cfg_if.cfg_addr = a;
    #1;
    check(name, int'(cfg_if.cfg_dout), int'(exp));
  endtask

  // Pulses cen for one clk and returns the cycle (relative to cen) on which sample is seen.
  task automatic run_frame(output int lat);
    cen = 1'b1;
    tick();
    cen = 1'b0;
    lat = 1;
    while (!sample && lat < 20) begin
      tick();
      lat++;
    end
    if (!sample) lat = -1;
  endtask

  task automatic set_gains(input logic [31:0] g);
    for (int k = 0; k < 4; k++) cfg_write(4'(k), g[8*k +: 8]);
  endtask

  initial begin
    int lat, samples, s1, s2, snd;

    vecs[0]  = mk("unity_mix",   pack(1000, -200, 300, 50),  32'h10101010, 4'b0000, 1150, 1'b0);
    vecs[1]  = mk("mixed_gains", pack(1000, 1000, -400, 7777), 32'h00102008, 4'b0000, 2100, 1'b0);
    vecs[2]  = mk("sat_pos",     pack(32767, 32767, 32767, 32767), 32'hFFFFFFFF, 4'b0000, 32767, 1'b1);
    vecs[3]  = mk("sat_neg",     pack(-32768, -32768, -32768, -32768), 32'hFFFFFFFF, 4'b0000, -32768, 1'b1);
    vecs[4]  = mk("mute_0101",   pack(100, 200, 300, 400),   32'h10101010, 4'b0101, 600, 1'b0);
    vecs[5]  = mk("all_muted",   pack(1000, 2000, 3000, 4000), 32'h10101010, 4'b1111, 0, 1'b0);
    vecs[6]  = mk("neg_floor",   pack(-1, 0, 0, 0),          32'h10101008, 4'b0000, -1, 1'b0);
    vecs[7]  = mk("gain_unsign", pack(1, 0, 0, 0),           32'h101010FF, 4'b0000, 15, 1'b0);
    vecs[8]  = mk("edge_max",    pack(32767, 0, 0, 0),       32'h10101010, 4'b0000, 32767, 1'b0);
    vecs[9]  = mk("over_max",    pack(32767, 1, 0, 0),       32'h10101010, 4'b0000, 32767, 1'b1);
    vecs[10] = mk("under_min",   pack(-32768, -1, 0, 0),     32'h10101010, 4'b0000, -32768, 1'b1);

    rstn = 1'b0; cen = 1'b0; ch_data = '0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 4'h0; cfg_if.cfg_din = 8'h00;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    check("rst_sound", int'(sound), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_overrun", int'(overrun), 0);
    cfg_check("rst_gain2", 4'h2, 8'h10);
    cfg_check("rst_ctrl", 4'hF, 8'h00);

    for (int i = 0; i < 11; i++) begin
      set_gains(vecs[i].gains);
      cfg_write(4'hF, {4'b1000, vecs[i].mute});
      ch_data = vecs[i].data;
      run_frame(lat);
      check({vecs[i].name, "_latency"}, lat, 6);
      check({vecs[i].name, "_sound"}, int'(sound), vecs[i].exp_sound);
      check({vecs[i].name, "_clip"}, int'(clip), int'(vecs[i].exp_clip));
      check({vecs[i].name, "_overrun"}, int'(overrun), 0);
      cfg_check({vecs[i].name, "_ctrl_rd"}, 4'hF, {vecs[i].exp_clip, 3'b000, vecs[i].mute});
      tick();
      check({vecs[i].name, "_pulse_1clk"}, int'(sample), 0);
    end

    // Saturate high, then low without clearing: clip stays set until bit 7 is written.
    set_gains(32'hFFFFFFFF);
    cfg_write(4'hF, 8'h80);
    ch_data = pack(32767, 32767, 32767, 32767);
    run_frame(lat);
    check("seq_sat_pos_sound", int'(sound), 32767);
    check("seq_sat_pos_clip", int'(clip), 1);
    ch_data = pack(-32768, -32768, -32768, -32768);
    run_frame(lat);
    check("seq_sat_neg_sound", int'(sound), -32768);
    check("seq_sat_neg_clip", int'(clip), 1);
    cfg_write(4'hF, 8'h80);
    check("seq_clip_cleared", int'(clip), 0);
    cfg_check("seq_ctrl_bit7_not_stored", 4'hF, 8'h00);

    // Second cen at cycle 3 is an overrun; gain/data changes mid-frame go to the next frame.
    set_gains(32'h10101010);
    cfg_write(4'hF, 8'h80);
    ch_data = pack(10, 20, 30, 40);
    samples = 0; s1 = -1; snd = 0;
    for (int c = 0; c < 12; c++) begin
      cen = (c == 0 || c == 3);
      cfg_if.cfg_we = 1'b0;
      if (c == 1) ch_data = pack(50, 60, 70, 80);
      if (c == 2) begin cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = 4'h0; cfg_if.cfg_din = 8'h20; end
      tick();
      if (sample) begin samples++; s1 = c + 1; snd = int'(sound); end
    end
    cen = 1'b0; cfg_if.cfg_we = 1'b0;
    check("ovr_sample_count", samples, 1);
    check("ovr_sample_cycle", s1, 6);
    check("ovr_sound_snapshot", snd, 100);
    check("ovr_flag", int'(overrun), 1);
    cfg_check("ovr_ctrl_rd", 4'hF, 8'h40);
    run_frame(lat);
    check("ovr_next_frame_sound", int'(sound), 310);
    check("ovr_next_frame_latency", lat, 6);

    // cen in OUT (cycle 5) is busy; cen in the following IDLE clk (cycle 6) starts a frame.
    cfg_write(4'h0, 8'h10);
    cfg_write(4'hF, 8'h80);
    ch_data = pack(16, 16, 16, 16);
    samples = 0; s1 = -1; s2 = -1;
    for (int c = 0; c < 16; c++) begin
      cen = (c == 0 || c == 5 || c == 6);
      tick();
      if (sample) begin
        samples++;
        if (s1 < 0) s1 = c + 1; else s2 = c + 1;
      end
    end
    cen = 1'b0;
    check("out_cen_sample_count", samples, 2);
    check("out_cen_first_cycle", s1, 6);
    check("out_cen_second_cycle", s2, 12);
    check("out_cen_overrun", int'(overrun), 1);
    check("out_cen_sound", int'(sound), 64);

    // Overrun set and clear in the same clk: the clear wins.
    cfg_write(4'hF, 8'h80);
    for (int c = 0; c < 8; c++) begin
      cen = (c == 0 || c == 3);
      cfg_if.cfg_we = (c == 3); cfg_if.cfg_addr = 4'hF; cfg_if.cfg_din = 8'h80;
      tick();
    end
    cen = 1'b0; cfg_if.cfg_we = 1'b0;
    check("clear_beats_set", int'(overrun), 0);

    // Unused addresses read FF and ignore writes.
    cfg_write(4'h5, 8'h33);
    cfg_check("addr4_reads_ff", 4'h4, 8'hFF);
    cfg_check("addr14_reads_ff", 4'hE, 8'hFF);
    cfg_check("gain1_untouched", 4'h1, 8'h10);

    // Reset in cycle 3 of a frame.
    cfg_write(4'h1, 8'h30);
    cfg_write(4'hF, 8'h03);
    ch_data = pack(500, 500, 500, 500);
    cen = 1'b1; tick(); cen = 1'b0;
    tick(); tick();
    check("pre_rst_sound_nonzero", int'(sound != 0), 1);
    rstn = 1'b0;
    #1;
    check("midrst_sound", int'(sound), 0);
    check("midrst_sample", int'(sample), 0);
    cfg_check("midrst_gain1", 4'h1, 8'h10);
    cfg_check("midrst_ctrl", 4'hF, 8'h00);
    samples = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sample) samples++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sample) samples++;
    end
    check("midrst_no_sample", samples, 0);
    check("midrst_sound_held", int'(sound), 0);
    ch_data = pack(1000, -200, 300, 50);
    run_frame(lat);
    check("postrst_sound", int'(sound), 1150);
    check("postrst_latency", lat, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jtdd_snd_mix.md
Name: jtdd_snd_mix

Overview:
- Parametrised, time-multiplexed sound mixer for the JTDD sound board; replaces the fixed three-input adder that sums FM and two ADPCM channels.
- Mixes CH signed channels with per-channel 4.4 gains and a per-channel mute.
- Uses a single multiply-accumulate stage, one channel per clock, started on each sample strobe.
- Produces a saturated output, a sample pulse and sticky clip/overrun flags readable by the sound CPU.

Parameters:
- CH, 4, number of input channels (2..8).
- W, 16, width of each signed channel input; the top level sign-extends and aligns narrower sources.
- OW, 16, signed output width (OW <= W+4).
- GAIN_RST, 8'h10, reset gain for every channel (4.4 fixed point, 1.0).

Ports:
- clk  in  1  system clock, 24 MHz.
- rstn  in  1  asynchronous active-low reset.
- cen  in  1  sample strobe; one clk wide; starts a mix frame.
- ch_data  in  CH*W  packed signed channel samples; channel k occupies bits [k*W+W-1 : k*W].
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  4  0..CH-1 selects a gain register; 4'hF selects the control register.
- cfg_din  in  8  write data. Gain register: gain. Control register: bits [CH-1:0] mute mask; bit 7 set clears both flags.
- cfg_dout  out  8  read data. cfg_addr < CH returns the gain; 4'hF returns {clip, overrun, mute[5:0]}, truncated to CH mute bits.
- sound  out  OW  signed mixed output.
- sample  out  1  one-clk pulse when sound updates.
- clip  out  1  sticky: saturation has occurred.
- overrun  out  1  sticky: cen arrived while a frame was busy.

Behaviour:
- Reset values: sound=0, sample=0, clip=0, overrun=0, gains=GAIN_RST, mute=0, FSM in IDLE, accumulator 0.
- FSM states:
  - IDLE: on cen, snapshot ch_data, gains and mute into shadow registers; clear acc; idx=0; go to MAC.
  - MAC: each clk, acc += muted ? 0 : shadow_data[idx]*shadow_gain[idx]; idx++. After the step with idx==CH-1, go to OUT.
  - OUT: compute res = acc >>> 4 (arithmetic shift); saturate res to OW bits; register sound; pulse sample for one clk; if saturation occurred set clip; return to IDLE.
- Latency: sample is asserted exactly CH+2 clks after the cen clk. With CH=4, cen at cycle 0 gives sample at cycle 6.
- Arithmetic: products are W+9 bits signed, with gain treated as unsigned 8 bits. acc width is W+9+clog2(CH); no intermediate overflow is possible.
- Saturation limits: +(2^(OW-1)-1) and -2^(OW-1).
- cen in MAC or OUT: ignored for mixing; set overrun. Frame in progress completes unaffected.
- cen in the same clk as the transition OUT->IDLE: treated as busy and sets overrun.
- cfg writes take effect on the next clk in the live registers. An in-progress frame uses its shadow copy; new values apply from the next frame.
- cfg_addr values in CH..14: writes ignored; reads return 8'hFF.
- Flag clear vs set in the same clk: the clear (bit 7) wins. Bit 7 is not stored.
- All channels muted: output is 0; sample still pulses.
- Reset mid-frame: immediate return to all reset values; no sample pulse; no partial output.
- cfg_dout is combinational from cfg_addr.

Test Plan:
- Unity gains, ch = {1000, -200, 300, 50}, cen → sound=1150 at cen+6, sample high for exactly 1 clk, clip=0.
- Gains {8'h08, 8'h20, 8'h10, 8'h00}, ch = {1000, 1000, -400, 7777} → 500+2000-400+0 = 2100.
- All ch = 16'h7FFF, gains 8'hFF → sound=16'h7FFF, clip=1. Then all ch = 16'h8000, gains 8'hFF → sound=16'h8000. Write 8'h80 to addr F → clip=0.
- cen at cycles 0 and 3 → one sample at cycle 6 with the cycle-0 data, overrun=1. Gain write at cycle 2 affects only the next frame.
- Mute mask 4'b0101, ch = {100, 200, 300, 400}, unity gains → 600. Read addr F returns mute bits 0101.
- rstn low at cycle 3 of a frame → no sample, sound=0, gains read back 8'h10. The next cen produces a correct frame.
